// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, default geometry and width helpers for the instruction cache
package icache_pkg;

    localparam int ICACHE_ADDR_WIDTH = 32;
    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_NUM_LINES  = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    // Geometry-derived widths for the default configuration
    localparam int ICACHE_OFFSET_W = $clog2(ICACHE_LINE_WORDS);
    localparam int ICACHE_INDEX_W  = $clog2(ICACHE_NUM_LINES);
    localparam int ICACHE_TAG_W    = ICACHE_ADDR_WIDTH - 2 - ICACHE_OFFSET_W - ICACHE_INDEX_W;

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2
    } state_e;

    // Width helpers so a non-default instance derives its own split
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_lines, input int line_words);
        return addr_width - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side, memory-side and control signals of the instruction cache
interface icache_if
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH
);
    // Fetch side
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_rd;
    logic [DATA_WIDTH-1:0] cache_data;
    logic                  cache_waitrequest;

    // Memory side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_waitrequest;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdatavalid;

    // Control
    logic                  invalidate;

    // Environment: drives fetch requests and answers memory reads
    modport master (
        output cache_addr, cache_rd, invalidate,
        output mem_waitrequest, mem_rdata, mem_rdatavalid,
        input  cache_data, cache_waitrequest,
        input  mem_addr, mem_rd
    );

    // Cache
    modport slave (
        input  cache_addr, cache_rd, invalidate,
        input  mem_waitrequest, mem_rdata, mem_rdatavalid,
        output cache_data, cache_waitrequest,
        output mem_addr, mem_rd
    );

endinterface

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - line data storage, one sync write port and one registered sync read port
module icache_data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Array contents are only ever meaningful once written by a fill
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Output word only changes when a read is accepted
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Registered read output, cleared by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with sequential line fill
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input logic   clock,
    input logic   reset_n,
    icache_if.slave bus
);
    localparam int OFF_W  = offset_bits(LINE_WORDS);
    localparam int IDX_W  = index_bits(NUM_LINES);
    localparam int TAG_W  = tag_bits(ADDR_WIDTH, NUM_LINES, LINE_WORDS);
    localparam int LINE_W = ADDR_WIDTH - 2 - OFF_W;
    localparam int RAM_AW = IDX_W + OFF_W;

    // Fetch address split; the byte lane bits are not used by a word fetch
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_byte_sel;

    assign req_off         = bus.cache_addr[2 +: OFF_W];
    assign req_idx         = bus.cache_addr[2 + OFF_W +: IDX_W];
    assign req_tag         = bus.cache_addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_byte_sel = ^bus.cache_addr[1:0];

    state_e               state_q, state_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic                 inv_pend_q, inv_pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    logic                  hit;
    logic                  tag_we;
    logic                  ram_we;
    logic                  ram_re;
    logic                  mem_rd;
    logic                  wait_req;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [DATA_WIDTH-1:0] cache_data;

    // The latched line address, not the live fetch address, steers the fill
    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LINE_W-1 -: TAG_W];
    assign hit      = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    // Next-state, handshake and array-update decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        inv_pend_d = inv_pend_q;
        valid_d    = valid_q;
        tag_we     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        mem_rd     = 1'b0;
        wait_req   = 1'b1;
        case (state_q)
            LOOKUP: begin
                if (bus.invalidate) begin
                    // Request is refused this cycle and retried after the flush
                    valid_d = '0;
                end else if (bus.cache_rd) begin
                    if (hit) begin
                        wait_req = 1'b0;
                        ram_re   = 1'b1;
                    end else begin
                        line_d  = bus.cache_addr[ADDR_WIDTH-1 -: LINE_W];
                        cnt_d   = '0;
                        state_d = FILL_REQ;
                    end
                end else begin
                    wait_req = 1'b0;
                end
            end
            FILL_REQ: begin
                mem_rd = 1'b1;
                if (bus.invalidate) begin
                    inv_pend_d = 1'b1;
                end
                if (!bus.mem_waitrequest) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (bus.invalidate) begin
                    inv_pend_d = 1'b1;
                end
                if (bus.mem_rdatavalid) begin
                    ram_we = 1'b1;
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        cnt_d      = '0;
                        tag_we     = 1'b1;
                        inv_pend_d = 1'b0;
                        state_d    = LOOKUP;
                        // A flush seen during the fill also discards this line
                        if (inv_pend_q || bus.invalidate) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fill_idx] = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    // Control state and valid bits, asynchronously cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOOKUP;
            cnt_q      <= '0;
            line_q     <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end
    end

    // Tag array written once per completed fill; no reset, valid bits guard it
    always_ff @(posedge clock) begin
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    icache_data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (RAM_AW)
    ) u_data_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (ram_we),
        .wr_addr ({fill_idx, cnt_q}),
        .wr_data (bus.mem_rdata),
        .rd_en   (ram_re),
        .rd_addr ({req_idx, req_off}),
        .rd_data (cache_data)
    );

    assign bus.cache_data        = cache_data;
    assign bus.cache_waitrequest = wait_req;
    assign bus.mem_rd            = mem_rd;
    assign bus.mem_addr          = {line_q, cnt_q, 2'b00};

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for the instruction cache
module tb_icache;

    logic clock;
    logic reset_n;

    icache_if bus ();

    icache u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Memory responder knobs (written by tests only)
    int bp_cycles    = 0;
    int rv_delay     = 0;
    bit inject_stray = 0;

    // Memory responder state (written by responder only)
    int          bp_left       = 0;
    bit          acc_flag      = 0;
    logic [31:0] acc_pend_addr = '0;
    bit          lat_active    = 0;
    int          lat           = 0;
    logic [31:0] pend_addr     = '0;
    int          acc_count     = 0;
    logic [31:0] acc_log [256];
    bit          hold_valid    = 0;
    logic [31:0] hold_addr     = '0;
    int          addr_unstable = 0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    // Memory model: one outstanding read, programmable stall and return delay
    always @(negedge clock) begin
        if (acc_flag) begin
            lat_active = 1;
            lat        = rv_delay;
            pend_addr  = acc_pend_addr;
            acc_flag   = 0;
        end
        bus.mem_rdatavalid = 1'b0;
        if (inject_stray) begin
            bus.mem_rdatavalid = 1'b1;
            bus.mem_rdata      = 32'hDEAD_BEEF;
        end else if (lat_active) begin
            if (lat == 0) begin
                bus.mem_rdatavalid = 1'b1;
                bus.mem_rdata      = mw(pend_addr);
                lat_active         = 0;
            end else begin
                lat--;
            end
        end
        if (bus.mem_rd) begin
            if (hold_valid && bus.mem_addr !== hold_addr) addr_unstable++;
            hold_addr  = bus.mem_addr;
            hold_valid = 1;
            if (bp_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                bp_left--;
            end else begin
                bus.mem_waitrequest = 1'b0;
                acc_flag            = 1;
                acc_pend_addr       = bus.mem_addr;
                acc_log[acc_count % 256] = bus.mem_addr;
                acc_count++;
                hold_valid          = 0;
            end
        end else begin
            bus.mem_waitrequest = 1'b0;
            bp_left             = bp_cycles;
            hold_valid          = 0;
        end
    end

    // Issue one read at a negedge, wait for acceptance, return data at the following negedge
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int stalls);
        bus.cache_addr = a;
        bus.cache_rd   = 1'b1;
        stalls         = 0;
        #1;
        while (bus.cache_waitrequest && stalls < 300) begin
            stalls++;
            @(negedge clock);
            #1;
        end
        if (stalls >= 300) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout addr=%h stalls=%0d required<300", a, stalls);
        end
        @(negedge clock);
        bus.cache_rd = 1'b0;
        d = bus.cache_data;
    endtask

    task automatic test_reset();
        reset_n            = 1'b0;
        bus.cache_addr     = '0;
        bus.cache_rd       = 1'b0;
        bus.invalidate     = 1'b0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_rdata      = '0;
        bus.mem_rdatavalid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", bus.mem_rd); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.cache_data !== 32'h0) begin errors++; $display("FAIL reset_cache_data got=%h exp=0", bus.cache_data); end
        checks++; if (bus.cache_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest got=%b exp=0", bus.cache_waitrequest); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_cold_miss();
        logic [31:0] d;
        int st;
        int base;
        base = acc_count;
        fetch(32'h100, d, st);
        checks++; if (st !== 9) begin errors++; $display("FAIL cold_stalls got=%0d exp=9", st); end
        checks++; if (acc_count - base !== 4) begin errors++; $display("FAIL cold_mem_reads got=%0d exp=4", acc_count - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_log[(base + i) % 256] !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL cold_fill_addr%0d got=%h exp=%h", i, acc_log[(base + i) % 256], 32'h100 + 32'(4 * i));
            end
        end
        checks++; if (d !== mw(32'h100)) begin errors++; $display("FAIL cold_data got=%h exp=%h", d, mw(32'h100)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + 32'(4 * i);
            bus.cache_addr = a;
            bus.cache_rd   = 1'b1;
            #1;
            checks++; if (bus.cache_waitrequest !== 1'b0) begin errors++; $display("FAIL stream_wait%0d got=%b exp=0", i, bus.cache_waitrequest); end
            checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL stream_mem_rd%0d got=%b exp=0", i, bus.mem_rd); end
            @(negedge clock);
            checks++; if (bus.cache_data !== mw(a)) begin errors++; $display("FAIL stream_data%0d got=%h exp=%h", i, bus.cache_data, mw(a)); end
        end
        bus.cache_rd   = 1'b0;
        bus.cache_addr = 32'h104;
        @(negedge clock);
        checks++; if (bus.cache_data !== mw(32'h10C)) begin errors++; $display("FAIL data_hold got=%h exp=%h", bus.cache_data, mw(32'h10C)); end
    endtask

    task automatic test_no_read();
        int base;
        base = acc_count;
        bus.cache_addr = 32'h5000;
        bus.cache_rd   = 1'b0;
        #1;
        checks++; if (bus.cache_waitrequest !== 1'b0) begin errors++; $display("FAIL idle_wait got=%b exp=0", bus.cache_waitrequest); end
        repeat (3) @(negedge clock);
        #1;
        checks++; if (acc_count !== base || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL idle_no_fill reads=%0d mem_rd=%b exp=0,0", acc_count - base, bus.mem_rd); end
        @(negedge clock);
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        int st;
        int base;
        base = acc_count;
        fetch(32'h1100, d, st);
        checks++; if (st !== 9) begin errors++; $display("FAIL conflict_stalls got=%0d exp=9", st); end
        checks++; if (acc_log[base % 256] !== 32'h1100) begin errors++; $display("FAIL conflict_fill_addr got=%h exp=00001100", acc_log[base % 256]); end
        checks++; if (d !== mw(32'h1100)) begin errors++; $display("FAIL conflict_data got=%h exp=%h", d, mw(32'h1100)); end
        fetch(32'h100, d, st);
        checks++; if (st !== 9) begin errors++; $display("FAIL conflict_remiss_stalls got=%0d exp=9", st); end
        checks++; if (d !== mw(32'h100)) begin errors++; $display("FAIL conflict_remiss_data got=%h exp=%h", d, mw(32'h100)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int st;
        int base;
        bp_cycles = 3;
        rv_delay  = 2;
        base = acc_count;
        addr_unstable = 0;
        fetch(32'h2200, d, st);
        checks++; if (st <= 12) begin errors++; $display("FAIL bp_stalls got=%0d exp>12", st); end
        checks++; if (addr_unstable !== 0) begin errors++; $display("FAIL bp_addr_stable changes=%0d exp=0", addr_unstable); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_log[(base + i) % 256] !== 32'h2200 + 32'(4 * i)) begin
                errors++; $display("FAIL bp_fill_addr%0d got=%h exp=%h", i, acc_log[(base + i) % 256], 32'h2200 + 32'(4 * i));
            end
        end
        checks++; if (d !== mw(32'h2200)) begin errors++; $display("FAIL bp_data0 got=%h exp=%h", d, mw(32'h2200)); end
        for (int i = 1; i < 4; i++) begin
            fetch(32'h2200 + 32'(4 * i), d, st);
            checks++;
            if (st !== 0 || d !== mw(32'h2200 + 32'(4 * i))) begin
                errors++; $display("FAIL bp_line_word%0d stalls=%0d data=%h exp=0,%h", i, st, d, mw(32'h2200 + 32'(4 * i)));
            end
        end
        bp_cycles = 0;
        rv_delay  = 0;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_invalidate();
        logic [31:0] d;
        int st;
        int base;
        fetch(32'h100, d, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL inv_pre_hit stalls=%0d exp=0", st); end
        bus.invalidate = 1'b1;
        bus.cache_rd   = 1'b1;
        bus.cache_addr = 32'h100;
        #1;
        checks++; if (bus.cache_waitrequest !== 1'b1) begin errors++; $display("FAIL inv_force_wait got=%b exp=1", bus.cache_waitrequest); end
        @(negedge clock);
        bus.invalidate = 1'b0;
        bus.cache_rd   = 1'b0;
        fetch(32'h2200, d, st);
        checks++; if (st !== 9) begin errors++; $display("FAIL inv_other_line_miss stalls=%0d exp=9", st); end
        fetch(32'h100, d, st);
        checks++; if (st !== 9 || d !== mw(32'h100)) begin errors++; $display("FAIL inv_miss_100 stalls=%0d data=%h exp=9,%h", st, d, mw(32'h100)); end

        // Flush pulse while the 0x200 line is being filled
        base = acc_count;
        bus.cache_addr = 32'h200;
        bus.cache_rd   = 1'b1;
        st = 0;
        #1;
        while (bus.cache_waitrequest && st < 300) begin
            st++;
            @(negedge clock);
            bus.invalidate = (st == 3);
            #1;
        end
        bus.invalidate = 1'b0;
        @(negedge clock);
        bus.cache_rd = 1'b0;
        d = bus.cache_data;
        checks++; if (st !== 18) begin errors++; $display("FAIL inv_fill_stalls got=%0d exp=18", st); end
        checks++; if (acc_count - base !== 8) begin errors++; $display("FAIL inv_fill_reads got=%0d exp=8", acc_count - base); end
        checks++; if (acc_log[(base + 4) % 256] !== 32'h200) begin errors++; $display("FAIL inv_refill_addr got=%h exp=00000200", acc_log[(base + 4) % 256]); end
        checks++; if (d !== mw(32'h200)) begin errors++; $display("FAIL inv_fill_data got=%h exp=%h", d, mw(32'h200)); end
        fetch(32'h20C, d, st);
        checks++; if (st !== 0 || d !== mw(32'h20C)) begin errors++; $display("FAIL inv_pending_cleared stalls=%0d data=%h exp=0,%h", st, d, mw(32'h20C)); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        int st;
        int base;
        int n;
        rv_delay = 4;
        base = acc_count;
        bus.cache_addr = 32'h100;
        bus.cache_rd   = 1'b1;
        n = 0;
        while (acc_count - base < 2 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++; if (n >= 100) begin errors++; $display("FAIL rst_wait_word1 reads=%0d exp=2", acc_count - base); end
        @(negedge clock);
        reset_n      = 1'b0;
        bus.cache_rd = 1'b0;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_rd got=%b exp=0", bus.mem_rd); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.cache_data !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs addr=%h data=%h exp=0,0", bus.mem_addr, bus.cache_data); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        #2;
        inject_stray = 1;
        @(negedge clock);
        #2;
        inject_stray = 0;
        @(negedge clock);
        #1;
        checks++; if (bus.mem_rd !== 1'b0 || bus.cache_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_stray_ignored mem_rd=%b wait=%b exp=0,0", bus.mem_rd, bus.cache_waitrequest); end
        rv_delay = 0;
        @(negedge clock);
        base = acc_count;
        fetch(32'h100, d, st);
        checks++; if (st !== 9) begin errors++; $display("FAIL rst_refill_stalls got=%0d exp=9", st); end
        checks++; if (acc_log[base % 256] !== 32'h100 || acc_log[(base + 3) % 256] !== 32'h10C) begin
            errors++; $display("FAIL rst_refill_order first=%h last=%h exp=00000100,0000010c", acc_log[base % 256], acc_log[(base + 3) % 256]);
        end
        checks++; if (d !== mw(32'h100)) begin errors++; $display("FAIL rst_refill_data got=%h exp=%h", d, mw(32'h100)); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_no_read();
        test_conflict();
        test_backpressure();
        test_invalidate();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, byte address width; DATA_WIDTH, 32, word width; NUM_LINES, 64, direct-mapped lines (power of 2); LINE_WORDS, 4, words per line (power of 2).
REQ-002 Ports SHALL be: clock  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-003 Fetch side: cache_addr  in  ADDR_WIDTH  byte address; cache_rd  in  1  read request; cache_data  out  DATA_WIDTH  instruction word; cache_waitrequest  out  1  request not accepted this cycle.
REQ-004 Memory side: mem_addr  out  ADDR_WIDTH  word-aligned fill address; mem_rd  out  1  fill read request; mem_waitrequest  in  1  memory not accepting; mem_rdata  in  DATA_WIDTH  fill data; mem_rdatavalid  in  1  mem_rdata valid.
REQ-005 Control: invalidate  in  1  single-cycle pulse, clear all valid bits.

Function
REQ-006 Address split SHALL be: bits[1:0] ignored; offset = next log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-007 Hit SHALL be valid[index] & (tag_array[index] == tag), evaluated combinationally from flop-based tag/valid arrays.
REQ-008 States SHALL be LOOKUP, FILL_REQ, FILL_WAIT.
REQ-009 In LOOKUP with cache_rd=1: hit -> cache_waitrequest=0 same cycle, request accepted; miss -> cache_waitrequest=1, latch line address, next state FILL_REQ.
REQ-010 cache_rd=0 SHALL give cache_waitrequest=0 and start no fill.
REQ-011 Accepted read in cycle N SHALL drive cache_data with the addressed word in cycle N+1 (one-cycle latency); cache_data SHALL hold its value when no read is accepted.
REQ-012 FILL_REQ: mem_rd=1, mem_addr={line address, word counter, 2'b00}; on mem_waitrequest=0 go to FILL_WAIT.
REQ-013 FILL_WAIT: mem_rd=0; on mem_rdatavalid=1 write mem_rdata to data RAM at {index, counter}, increment counter; counter < LINE_WORDS-1 -> FILL_REQ, else write tag, set valid, counter=0, go to LOOKUP.
REQ-014 Fill order SHALL be sequential from word 0; one outstanding memory read at a time; mem_rdatavalid outside FILL_WAIT SHALL be ignored.
REQ-015 cache_waitrequest SHALL be 1 throughout FILL_REQ and FILL_WAIT; the first LOOKUP cycle after a fill re-evaluates and hits.
REQ-016 invalidate in LOOKUP SHALL clear all valid bits at the next edge and force cache_waitrequest=1 that cycle.
REQ-017 invalidate during a fill SHALL be latched; on fill completion all valid bits clear and the filled line is NOT validated; the pending flag then clears.
REQ-018 Fetch address changing during a fill SHALL not alter the fill; the new address is looked up on return to LOOKUP.

Reset
REQ-019 reset_n low SHALL asynchronously force: state=LOOKUP, all valid bits=0, word counter=0, invalidate-pending=0, mem_rd=0, mem_addr=0, cache_data=0.
REQ-020 Reset mid-fill SHALL abort the fill; late mem_rdatavalid after reset release SHALL be ignored (state LOOKUP).
REQ-021 Tag array and data RAM contents need no reset.

Structure
REQ-022 Package icache_pkg SHALL hold the state enum and geometry-derived localparams (offset/index/tag widths).
REQ-023 Data storage SHALL be sub-module icache_data_ram: NUM_LINES*LINE_WORDS x DATA_WIDTH, one sync write port, one sync read port, registered read output.

Verification
REQ-024 Cold miss: after reset, cache_rd=1, addr 0x00000100 -> mem reads at 0x100,0x104,0x108,0x10C; waitrequest=1 until fill ends; then hit, cache_data=word@0x100 next cycle.
REQ-025 Streaming hits: after fill, addresses 0x100,0x104,0x108,0x10C back-to-back -> waitrequest=0 each cycle, data returned in order at N+1, mem_rd stays 0.
REQ-026 Conflict: fill 0x100 then read 0x1100 (same index, tag differs) -> miss, refill, then 0x100 misses again.
REQ-027 Backpressure: mem_waitrequest=1 for 3 cycles per word, rdatavalid 2 cycles later -> mem_addr stable while mem_rd=1, correct line written.
REQ-028 Invalidate: pulse in LOOKUP after fill -> 0x100 misses; pulse during fill of 0x200 -> fill completes, 0x200 misses again.
REQ-029 Reset mid-fill after word 1 -> mem_rd=0 immediately, valid=0, stray rdatavalid ignored, re-request of 0x100 refills from word 0.
